// File: rtl/jof32_mem_pkg.sv
// Shared size codes, FSM encoding and big-endian lane constants for the
// load/store sequencer (mem_access_ctrl and mem_lane_align).
package jof32_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_WAIT = 3'd1,
        LOAD_DONE = 3'd2,
        RMW_READ  = 3'd3,
        RMW_WRITE = 3'd4
    } state_t;

    // Big-endian: lane 0 is bits [31:24], lane 3 is bits [7:0]
    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

    // Size code 11 behaves as a word access
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    // Right-shift that brings a byte lane down to bits [7:0]: (3 - lane) * 8
    function automatic logic [4:0] lane_shift(input logic [1:0] lane);
        return {~lane, 3'b000};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extracts and extends sub-word loads, and merges
// sub-word store data into the word read back from RAM.
module mem_lane_align
    import jof32_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [1:0]  lane;
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        lane = LANE_0;
        if (size == SIZE_BYTE) begin
            lane = offset;
        end else if (size == SIZE_HALF) begin
            lane = {offset[1], 1'b0};
        end
    end

    // A half spans lane and lane+1; the lower-significance lane sets the shift
    assign byte_sh  = lane_shift(lane);
    assign half_sh  = lane_shift(lane | LANE_1);
    assign byte_val = 8'(word >> byte_sh);
    assign half_val = 16'(word >> half_sh);

    always_comb begin
        load_data = word;
        merged    = wdata;
        case (size)
            SIZE_BYTE: begin
                load_data = {{24{sign_ext & byte_val[7]}}, byte_val};
                merged    = (word & ~(32'h0000_00FF << byte_sh)) | (32'(wdata[7:0]) << byte_sh);
            end
            SIZE_HALF: begin
                load_data = {{16{sign_ext & half_val[15]}}, half_val};
                merged    = (word & ~(32'h0000_FFFF << half_sh)) | (32'(wdata[15:0]) << half_sh);
            end
            default: begin
                load_data = word;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store sequencer in front of a 1-cycle-latency single-port RAM.
// Optional MEM_MISALIGN_TRAP_EN rejects misaligned half/word accesses via misalign_err.
//
// state     | meaning
// ----------|---------------------------------------------------------------
// IDLE      | accept request; word store writes here, others present address
// LOAD_WAIT | ram_q valid, extract/extend lane into rdata
// LOAD_DONE | rdata_valid, load retires
// RMW_READ  | ram_q valid, merge store lane into word
// RMW_WRITE | write merged word, store retires
module mem_access_ctrl
    import jof32_mem_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_data,
    output logic              ram_wren,
    input  logic [31:0]       ram_q,
    output logic              stall,
    output logic              rdata_valid,
    output logic [31:0]       rdata
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              misalign_err
`endif
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] index_q;
    logic [1:0]        offset_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merged_q;
    logic [31:0]       rdata_q;
    logic [1:0]        offset_in;
    logic              misaligned;
    logic              accept;
    logic              word_store;
    logic [31:0]       load_data;
    logic [31:0]       merged;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = ((req_size == SIZE_HALF) & req_addr[0]) |
                        (is_word(req_size) & (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        offset_in = req_addr[1:0];
        if (req_size == SIZE_HALF) begin
            offset_in[0] = 1'b0;
        end else if (is_word(req_size)) begin
            offset_in = 2'b00;
        end
    end

    assign accept     = req_valid & ~rst & (state == IDLE) & ~misaligned;
    assign word_store = accept & req_we & is_word(req_size);

    mem_lane_align u_align (
        .size      (size_q),
        .offset    (offset_q),
        .sign_ext  (signed_q),
        .word      (ram_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            index_q  <= '0;
            offset_q <= 2'b00;
            size_q   <= SIZE_WORD;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                index_q  <= req_addr[ADDR_W+1:2];
                offset_q <= offset_in;
                size_q   <= req_size;
                signed_q <= req_signed;
                wdata_q  <= req_wdata;
            end
            if (state == LOAD_WAIT) begin
                rdata_q <= load_data;
            end
            if (state == RMW_READ) begin
                merged_q <= merged;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!req_we) begin
                        state_nxt = LOAD_WAIT;
                    end else if (!is_word(req_size)) begin
                        state_nxt = RMW_READ;
                    end
                end
            end
            LOAD_WAIT: state_nxt = LOAD_DONE;
            LOAD_DONE: state_nxt = IDLE;
            RMW_READ:  state_nxt = RMW_WRITE;
            RMW_WRITE: state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Every output is gated by rst so an aborted access never writes or retires
    always_comb begin
        ram_address = index_q;
        ram_data    = merged_q;
        ram_wren    = 1'b0;
        stall       = 1'b0;
        rdata_valid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_err = 1'b0;
`endif
        case (state)
            IDLE: begin
                ram_address = req_addr[ADDR_W+1:2];
                if (word_store) begin
                    ram_wren = 1'b1;
                    ram_data = req_wdata;
                end else if (accept) begin
                    stall = 1'b1;
                end
`ifdef MEM_MISALIGN_TRAP_EN
                misalign_err = req_valid & ~rst & misaligned;
`endif
            end
            LOAD_WAIT: stall       = ~rst;
            RMW_READ:  stall       = ~rst;
            LOAD_DONE: rdata_valid = ~rst;
            RMW_WRITE: ram_wren    = ~rst;
            default: ;
        endcase
    end

    assign rdata = rdata_q;

endmodule
